dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that services the processor's load/store path (LW, SW, LB, SB) and produces the `hit` signal used to gate PC advancement. It sits between the datapath (address from ALU result, store data from register file) and the block-wide main memory, and it owns the miss-handling state machine that stalls the processor until the requested line is resident.

---
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits complete in zero cycles; misses stall through an optional writeback and a line fill.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic         is_byte,
  output logic [31:0]  cpu_rdata,
  output logic         hit,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  output logic         mem_re,
  output logic         mem_we,
  input  logic         mem_ready
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [127:0]        line_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            word_sel, byte_sel;
  logic                  req, lookup_hit, write_hit, fill_done;
  logic [127:0]          cur_line, merged_line;
  logic [31:0]           cur_word, merged_word;
  logic [7:0]            cur_byte;

  assign idx      = cpu_addr[4 +: INDEX_BITS];
  assign req_tag  = cpu_addr[31 -: TAG_BITS];
  assign word_sel = cpu_addr[3:2];
  assign byte_sel = cpu_addr[1:0];
  assign req      = cpu_read | cpu_write;

  assign cur_line = line_q[idx];
  assign cur_word = cur_line[{word_sel, 5'b0} +: 32];
  assign cur_byte = cur_word[{byte_sel, 3'b0} +: 8];

  // Lookup is purely combinational through the tag array, so hits cost no cycle.
  assign lookup_hit = req & valid_q[idx] & (tag_q[idx] == req_tag)
                    & (state_q == S_IDLE) & ~reset;
  assign write_hit  = lookup_hit & cpu_write;
  assign fill_done  = (state_q == S_FILL) & mem_ready & ~reset;

  assign hit = lookup_hit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cpu_rdata = 32'h0;
    if (lookup_hit) begin
      cpu_rdata = is_byte ? {{24{cur_byte[7]}}, cur_byte} : cur_word;
    end
  end

  always_comb begin
    merged_word = cur_word;
    if (is_byte) begin
      merged_word[{byte_sel, 3'b0} +: 8] = cpu_wdata[7:0];
    end else begin
      merged_word = cpu_wdata;
    end
    merged_line = cur_line;
    merged_line[{word_sel, 5'b0} +: 32] = merged_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !lookup_hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL;
        end
      end
      S_WB:    if (mem_ready) state_d = S_FILL;
      S_FILL:  if (mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_q[idx] <= mem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (write_hit) begin
      line_q[idx] <= merged_line;
    end
  end

  assign mem_re    = ~reset & (state_q == S_FILL);
  assign mem_we    = ~reset & (state_q == S_WB);
  assign mem_wdata = cur_line;

  always_comb begin
    mem_addr = 32'h0;
    if (!reset) begin
      case (state_q)
        S_WB:    mem_addr = {tag_q[idx], idx, 4'h0};
        S_FILL:  mem_addr = {cpu_addr[31:4], 4'h0};
        default: mem_addr = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a latency-3 memory responder plus a scoreboard
// queue of expected load data and stall lengths, popped when the cache reports a hit.
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk;
  logic         reset;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic         cpu_read, cpu_write, is_byte, hit;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_re, mem_we, mem_ready;
  logic         mem_ready_m, stray_ready;

  assign mem_ready = mem_ready_m | stray_ready;

  dcache_ctrl #(.INDEX_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .is_byte   (is_byte),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_ready (mem_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          stall;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] mem [logic [31:0]];
  int           n_cmp = 0;
  int           n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: acknowledges each transfer on its LAT-th cycle, storing writebacks and serving fills.
  initial begin
    int cnt;
    cnt         = 0;
    mem_ready_m = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (reset || !(mem_re || mem_we)) begin
        mem_ready_m = 1'b0;
        cnt         = 0;
      end else if (cnt == LAT - 1) begin
        mem_ready_m = 1'b1;
        cnt         = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : {4{mem_addr}};
      end else begin
        mem_ready_m = 1'b0;
        cnt++;
      end
    end
  end

  // Issue one request at a negedge, hold it until hit, and score data, stall and memory traffic.
  task automatic access(input string name, input logic rd, input logic wr, input logic byt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit chk_rd, input int exp_stall,
                        input int exp_nfill, input int exp_nwb,
                        input logic [31:0] wb_addr, input logic [127:0] wb_line);
    exp_t e;
    int   cycles, nf, nw;
    bit   got;
    e = '{name, exp_rd, chk_rd, exp_stall};
    sb_q.push_back(e);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_read  = rd;
    cpu_write = wr;
    is_byte   = byt;
    cycles = 0; nf = 0; nw = 0; got = 1'b0;
    while (!got && cycles < 60) begin
      #1;
      if (hit) begin
        got = 1'b1;
      end else begin
        if (mem_re) begin
          nf++;
          check({name, " fill_addr"}, mem_addr, {addr[31:4], 4'h0});
          check({name, " re_we_excl"}, mem_we, 1'b0);
        end
        if (mem_we) begin
          nw++;
          check({name, " wb_addr"}, mem_addr, wb_addr);
          check({name, " wb_data"}, mem_wdata, wb_line);
        end
        @(negedge clk);
        cycles++;
      end
    end
    check({name, " hit_seen"}, got, 1'b1);
    e = sb_q.pop_front();
    if (got) begin
      if (e.chk_rdata) check({e.name, " rdata"}, cpu_rdata, e.rdata);
      check({e.name, " stall"}, 128'(cycles), 128'(e.stall));
      check({e.name, " fill_cycles"}, 128'(nf), 128'(exp_nfill));
      check({e.name, " wb_cycles"}, 128'(nw), 128'(exp_nwb));
    end
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    is_byte   = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    stray_ready = 1'b0;
    cpu_addr    = 32'h10;
    cpu_wdata   = 32'h0;
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    is_byte     = 1'b0;
    mem[32'h10]  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem[32'h210] = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

    // Outputs held at reset values while reset is high, even with a request present.
    @(negedge clk);
    #1;
    check("rst hit", hit, 1'b0);
    check("rst mem_re", mem_re, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst cpu_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    cpu_read = 1'b0;

    // Clean read miss, then a hit elsewhere in the same line.
    access("lw_10_miss", 1, 0, 0, 32'h10, 0, 32'h11111111, 1, 1 + LAT, LAT, 0, 0, 0);
    access("lw_1c_hit",  1, 0, 0, 32'h1C, 0, 32'h44444444, 1, 0, 0, 0, 0, 0);

    // Word store then load.
    access("sw_14", 0, 1, 0, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    access("lw_14", 1, 0, 0, 32'h14, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);

    // Byte lanes with sign extension.
    access("sb_13", 0, 1, 1, 32'h13, 32'h000000AB, 0, 0, 0, 0, 0, 0, 0);
    access("lb_13", 1, 0, 1, 32'h13, 0, 32'hFFFFFFAB, 1, 0, 0, 0, 0, 0);
    access("sb_12", 0, 1, 1, 32'h12, 32'h0000007F, 0, 0, 0, 0, 0, 0, 0);
    access("lb_12", 1, 0, 1, 32'h12, 0, 32'h0000007F, 1, 0, 0, 0, 0, 0);
    access("lw_10_merged", 1, 0, 0, 32'h10, 0, 32'hAB7F1111, 1, 0, 0, 0, 0, 0);

    // Read and write together act as a write.
    access("rw_14", 1, 1, 0, 32'h14, 32'h00000005, 0, 0, 0, 0, 0, 0, 0);

    // Stray mem_ready in IDLE must not move the controller.
    stray_ready = 1'b1;
    #1;
    check("stray hit", hit, 1'b0);
    check("stray mem_re", mem_re, 1'b0);
    @(negedge clk);
    stray_ready = 1'b0;
    #1;
    check("post_stray mem_re", mem_re, 1'b0);
    check("post_stray mem_we", mem_we, 1'b0);
    @(negedge clk);
    access("lw_14_rw", 1, 0, 0, 32'h14, 0, 32'h00000005, 1, 0, 0, 0, 0, 0);

    // Dirty conflict miss on index 1: writeback of the modified line, then fill of 0x210.
    access("lw_210_dirty", 1, 0, 0, 32'h210, 0, 32'hA0A0A0A0, 1, 1 + 2 * LAT, LAT, LAT,
           32'h10, {32'h44444444, 32'h33333333, 32'h00000005, 32'hAB7F1111});
    check("mem_10 written_back", mem[32'h10],
          {32'h44444444, 32'h33333333, 32'h00000005, 32'hAB7F1111});
    // Victim 0x210 is clean, so the refill of 0x10 skips writeback and returns the stored data.
    access("lw_10_refill", 1, 0, 0, 32'h10, 0, 32'hAB7F1111, 1, 1 + LAT, LAT, 0, 0, 0);

    // Reset during a fill abandons the transfer and invalidates every line.
    cpu_addr = 32'h20;
    cpu_read = 1'b1;
    @(negedge clk);
    #1;
    check("midfill mem_re", mem_re, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("after_rst mem_re", mem_re, 1'b0);
    check("after_rst mem_we", mem_we, 1'b0);
    @(negedge clk);
    access("lw_10_after_rst", 1, 0, 0, 32'h10, 0, 32'hAB7F1111, 1, 1 + LAT, LAT, 0, 0, 0);
    access("lw_14_after_rst", 1, 0, 0, 32'h14, 0, 32'h00000005, 1, 0, 0, 0, 0, 0);

    check("scoreboard empty", 128'(sb_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
